// File: rtl/column_input_ctrl_pkg.sv
// Shared Connect4 definitions for the player-input stage:
// game status codes, board geometry and drop FSM states.
package column_input_ctrl_pkg;

  localparam logic [1:0] GS_PLAYING = 2'b00;
  localparam logic [1:0] GS_P1_WIN  = 2'b01;
  localparam logic [1:0] GS_P2_WIN  = 2'b10;
  localparam logic [1:0] GS_DRAW    = 2'b11;

  localparam int NUM_ROWS     = 4;
  localparam int NUM_COLS     = 4;
  localparam int TOP_ROW_BASE = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } drop_state_t;

  function automatic logic [3:0] col_onehot(
    input logic [1:0] c
  );
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/column_input_ctrl_if.sv
// Button/board/status inputs and move outputs of the
// column input stage, grouped for the DUT and its driver.
interface column_input_ctrl_if;
  logic        btn_left;
  logic        btn_right;
  logic        btn_drop;
  logic [15:0] in_gameboard;
  logic [1:0]  in_game_status;
  logic [3:0]  out_column;
  logic        out_enable;
  logic [3:0]  out_cursor;
  logic        out_invalid;

  modport slave (
    input  btn_left,
    input  btn_right,
    input  btn_drop,
    input  in_gameboard,
    input  in_game_status,
    output out_column,
    output out_enable,
    output out_cursor,
    output out_invalid
  );

  modport master (
    output btn_left,
    output btn_right,
    output btn_drop,
    output in_gameboard,
    output in_game_status,
    input  out_column,
    input  out_enable,
    input  out_cursor,
    input  out_invalid
  );
endinterface

// File: rtl/column_input_ctrl_button_debouncer.sv
// Raw button -> 2-flop sync -> debounced level, plus a
// registered one-cycle pulse the cycle after a rising edge.
module column_input_ctrl_button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic             s1;
  logic             s2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // sync, debounce counter, level and rising-edge pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      level_d <= level;
      rise    <= level & ~level_d;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/column_input_ctrl.sv
// Player input stage: debounced buttons drive a wrapping
// cursor and a legal-only single-cycle drop command.
module column_input_ctrl
  import column_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int HOLDOFF_CYCLES  = 4
) (
  input logic               clk,
  input logic               reset,
  column_input_ctrl_if.slave bus
);

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  logic          l_rise;
  logic          r_rise;
  logic          d_rise;
  logic          l_level;
  logic          r_level;
  logic          d_level;
  logic [1:0]    cursor;
  logic [1:0]    cur_nxt;
  logic          mv_l;
  logic          mv_r;
  logic          legal;
  logic [3:0]    top_row;
  logic [HW-1:0] hold_cnt;
  drop_state_t   state;

  column_input_ctrl_button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_left (
    .clk  (clk),
    .reset(reset),
    .btn  (bus.btn_left),
    .level(l_level),
    .rise (l_rise)
  );

  column_input_ctrl_button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_right (
    .clk  (clk),
    .reset(reset),
    .btn  (bus.btn_right),
    .level(r_level),
    .rise (r_rise)
  );

  column_input_ctrl_button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_drop (
    .clk  (clk),
    .reset(reset),
    .btn  (bus.btn_drop),
    .level(d_level),
    .rise (d_rise)
  );

  assign mv_l    = l_rise & ~r_rise & ~d_rise;
  assign mv_r    = r_rise & ~l_rise & ~d_rise;
  assign top_row = bus.in_gameboard[TOP_ROW_BASE +: 4];
  assign legal   = (bus.in_game_status == GS_PLAYING)
                 & ~top_row[cursor];

  // next cursor; conflicting or drop-coincident moves drop out
  always_comb begin
    cur_nxt = cursor;
    unique case (1'b1)
      mv_l:    cur_nxt = (cursor == 2'd0)
                       ? 2'(NUM_COLS - 1)
                       : cursor - 2'd1;
      mv_r:    cur_nxt = (cursor == 2'(NUM_COLS - 1))
                       ? 2'd0
                       : cursor + 2'd1;
      default: ;
    endcase
  end

  // cursor register and its one-hot LED copy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor         <= 2'd0;
      bus.out_cursor <= 4'b0001;
    end else begin
      cursor         <= cur_nxt;
      bus.out_cursor <= col_onehot(cur_nxt);
    end
  end

  // drop FSM: issue legal drops, then hold off until release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      hold_cnt        <= '0;
      bus.out_column  <= 4'd0;
      bus.out_enable  <= 1'b0;
      bus.out_invalid <= 1'b0;
    end else begin
      bus.out_enable  <= 1'b0;
      bus.out_invalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (d_rise) begin
            if (legal) begin
              bus.out_column <= {2'b00, cursor};
              bus.out_enable <= 1'b1;
              state          <= ISSUE;
            end else begin
              bus.out_invalid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          hold_cnt <= HW'(HOLDOFF_CYCLES);
          state    <= HOLDOFF;
        end
        HOLDOFF: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
          end else if (!d_level) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_column_input_ctrl.sv
// Scoreboard bench for column_input_ctrl with a short
// debounce window; drop outcomes are queued at stimulus time.
module tb_column_input_ctrl;

  localparam int DB = 4;

  typedef struct {
    logic [1:0] kind;
    int         col;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cur = 0;
  exp_t q[$];
  exp_t e_m;

  column_input_ctrl_if bus ();

  column_input_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (3),
    .HOLDOFF_CYCLES (4)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.out_enable || bus.out_invalid)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse",
              {30'd0, bus.out_enable, bus.out_invalid},
              32'd0);
      end else begin
        e_m = q.pop_front();
        check("pulse_kind",
              {30'd0, bus.out_enable, bus.out_invalid},
              {30'd0, e_m.kind});
        if (bus.out_enable)
          check("out_column", {28'd0, bus.out_column},
                e_m.col);
        check("latency", cyc, e_m.cyc);
      end
    end
  end

  task automatic press(
    input int which,
    input int hold,
    input int gap
  );
    @(negedge clk);
    case (which)
      0: bus.btn_left  = 1'b1;
      1: bus.btn_right = 1'b1;
      default: bus.btn_drop = 1'b1;
    endcase
    repeat (hold) @(negedge clk);
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_drop  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic move(input int which);
    press(which, 8, 10);
    cur = (which == 0) ? (cur + 3) % 4 : (cur + 1) % 4;
    check("out_cursor", {28'd0, bus.out_cursor},
          32'd1 << cur);
  endtask

  task automatic drop(
    input bit ok,
    input int hold,
    input int gap
  );
    exp_t e;
    @(negedge clk);
    e.kind = ok ? 2'b10 : 2'b01;
    e.col  = cur;
    e.cyc  = cyc + DB + 4;
    q.push_back(e);
    bus.btn_drop = 1'b1;
    repeat (hold) @(negedge clk);
    bus.btn_drop = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic goto(input int col);
    for (int i = 0; i < 4 && cur != col; i++) move(1);
  endtask

  initial begin
    bus.btn_left       = 1'b0;
    bus.btn_right      = 1'b0;
    bus.btn_drop       = 1'b0;
    bus.in_gameboard   = 16'h0000;
    bus.in_game_status = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_cursor", {28'd0, bus.out_cursor}, 32'h1);
    check("rst_enable", {31'd0, bus.out_enable}, 32'h0);
    check("rst_invalid", {31'd0, bus.out_invalid}, 32'h0);
    check("rst_column", {28'd0, bus.out_column}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: long hold gives exactly one drop at column 0
    drop(1'b1, 20, 15);
    check("col_hold", {28'd0, bus.out_column}, 32'd0);

    // 2: right x3, left x2, then wrap below zero
    move(1); move(1); move(1);
    move(0); move(0);
    move(0); move(0);

    // 3: full column rejected, neighbour accepted
    bus.in_gameboard = 16'h2000;
    goto(1);
    drop(1'b0, 8, 15);
    move(1);
    drop(1'b1, 8, 15);
    check("col_held", {28'd0, bus.out_column}, 32'd2);

    // 4: game over rejects, cursor still moves
    bus.in_game_status = 2'b01;
    drop(1'b0, 8, 15);
    move(1);
    move(0);
    bus.in_game_status = 2'b00;
    bus.in_gameboard   = 16'h0000;

    // 5: short glitch ignored; second press in holdoff ignored
    press(2, 3, 12);
    drop(1'b1, 8, 2);
    press(2, 8, 25);

    // 6: reset during holdoff, then a fresh drop
    goto(3);
    drop(1'b1, 10, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_cursor", {28'd0, bus.out_cursor}, 32'h1);
    check("rst2_enable", {31'd0, bus.out_enable}, 32'h0);
    check("rst2_invalid", {31'd0, bus.out_invalid}, 32'h0);
    check("rst2_column", {28'd0, bus.out_column}, 32'h0);
    rst = 1'b0;
    cur = 0;
    repeat (3) @(negedge clk);
    drop(1'b1, 8, 15);

    for (int i = 0; i < 50 && q.size() != 0; i++)
      @(negedge clk);
    check("sb_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
